// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared fetch-stage definitions: bubble word, PC step, FSM encoding, IF/ID layout, RS/RT field positions.
package fetch_stage_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC_DEF   = 32'd4;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef enum logic {
        FETCH_REQ  = 1'b0,
        FETCH_HELD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus;
        logic        vld;
    } if_id_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus;
    } skid_t;

    localparam int IF_ID_W = $bits(if_id_t);

    function automatic logic [4:0] rs_field(input logic [31:0] w);
        return w[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] rt_field(input logic [31:0] w);
        return w[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/fetch_stage_ctrl_if_id_reg.sv
// Pipeline register with load enable and synchronous clear-to-bubble.
// Latency: 1 cycle from d to q.
// Backpressure: en=0 holds contents; clr wins over en.
module if_id_reg #(
    parameter int             W       = 65,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= CLR_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// IF stage: PC, instruction-memory req/ready fetch, one-entry skid buffer, IF/ID register.
// Latency: fetched word lands in IF/ID 1 cycle after the IMemReady edge.
// Backpressure: Stall freezes IF/ID; a word returning under Stall parks in the skid (HELD).
module fetch_stage_ctrl
    import fetch_stage_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_INC   = PC_INC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        FlushIF,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemRdata,
    output logic [31:0] Instruction_ID,
    output logic [31:0] PCPlus4_ID,
    output logic        Valid_ID,
    output logic [4:0]  RS_ID,
    output logic [4:0]  RT_ID
);

    localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE = {NOP_WORD, 32'h0, 1'b0};

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt, pc_inc;
    skid_t        skid, skid_nxt;
    logic         fire;
    logic         ifid_en, ifid_clr;
    if_id_t       ifid_d, ifid_q;

    assign pc_inc   = pc + PC_INC;
    assign fire     = (state == FETCH_REQ) && IMemReady;
    // Request is masked while reset is asserted; state already sits in REQ.
    assign IMemReq  = (state == FETCH_REQ) && Rst_n;
    assign IMemAddr = pc;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= FETCH_REQ;
            pc    <= RESET_PC;
            skid  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            skid  <= skid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        skid_nxt  = skid;
        ifid_en   = 1'b0;
        ifid_clr  = 1'b0;
        ifid_d    = '{instr: IMemRdata, pc_plus: pc_inc, vld: 1'b1};

        if (BranchTaken) begin
            // Redirect discards any return this cycle and any parked word.
            pc_nxt    = BranchTarget;
            ifid_clr  = 1'b1;
            state_nxt = FETCH_REQ;
        end else if (FlushIF) begin
            ifid_clr  = 1'b1;
            state_nxt = FETCH_REQ;
            if (fire) begin
                pc_nxt = pc_inc;
            end
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (fire) begin
                        pc_nxt = pc_inc;
                        if (Stall) begin
                            skid_nxt  = '{instr: IMemRdata, pc_plus: pc_inc};
                            state_nxt = FETCH_HELD;
                        end else begin
                            ifid_en = 1'b1;
                        end
                    end else if (!Stall) begin
                        ifid_clr = 1'b1;
                    end
                end
                FETCH_HELD: begin
                    if (!Stall) begin
                        ifid_en   = 1'b1;
                        ifid_d    = '{instr: skid.instr, pc_plus: skid.pc_plus, vld: 1'b1};
                        state_nxt = FETCH_REQ;
                    end
                end
                default: state_nxt = FETCH_REQ;
            endcase
        end
    end

    if_id_reg #(
        .W       (IF_ID_W),
        .CLR_VAL (IF_ID_BUBBLE)
    ) u_if_id (
        .clk   (Clk),
        .rst_n (Rst_n),
        .en    (ifid_en),
        .clr   (ifid_clr),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign Instruction_ID = ifid_q.instr;
    assign PCPlus4_ID     = ifid_q.pc_plus;
    assign Valid_ID       = ifid_q.vld;
    assign RS_ID          = rs_field(ifid_q.instr);
    assign RT_ID          = rt_field(ifid_q.instr);

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl with a scoreboard of expected IF/ID entries.
module tb_fetch_stage_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Stall;
    logic        FlushIF;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemRdata;
    logic [31:0] Instruction_ID;
    logic [31:0] PCPlus4_ID;
    logic        Valid_ID;
    logic [4:0]  RS_ID;
    logic [4:0]  RT_ID;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   tests = 0;
    int   fails = 0;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3 ^ {a[15:0], a[31:16]};
    endfunction

    assign IMemRdata = mem_word(IMemAddr);

    fetch_stage_ctrl dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Stall          (Stall),
        .FlushIF        (FlushIF),
        .BranchTaken    (BranchTaken),
        .BranchTarget   (BranchTarget),
        .IMemReq        (IMemReq),
        .IMemAddr       (IMemAddr),
        .IMemReady      (IMemReady),
        .IMemRdata      (IMemRdata),
        .Instruction_ID (Instruction_ID),
        .PCPlus4_ID     (PCPlus4_ID),
        .Valid_ID       (Valid_ID),
        .RS_ID          (RS_ID),
        .RT_ID          (RT_ID)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] a);
        sb.push_back(exp_t'{instr: mem_word(a), pc4: a + 32'd4});
    endtask

    // One clock; then check IF/ID against the scoreboard, the frozen entry, or a bubble.
    task automatic tick();
        logic st_at_edge;
        exp_t e;
        st_at_edge = Stall;
        @(posedge Clk);
        #1;
        if (Valid_ID === 1'b1 && !st_at_edge) begin
            chk("sb_avail", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("instr_id", {32'd0, Instruction_ID}, {32'd0, e.instr});
                chk("pcplus4_id", {32'd0, PCPlus4_ID}, {32'd0, e.pc4});
                chk("rs_id", {59'd0, RS_ID}, {59'd0, e.instr[25:21]});
                chk("rt_id", {59'd0, RT_ID}, {59'd0, e.instr[20:16]});
                last_exp = e;
            end
        end else if (Valid_ID === 1'b1) begin
            chk("frozen_instr", {32'd0, Instruction_ID}, {32'd0, last_exp.instr});
            chk("frozen_pc4", {32'd0, PCPlus4_ID}, {32'd0, last_exp.pc4});
        end else begin
            chk("bubble_valid", {63'd0, Valid_ID}, 64'd0);
            chk("bubble_instr", {32'd0, Instruction_ID}, 64'd0);
            chk("bubble_rs_rt", {54'd0, RS_ID, RT_ID}, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        last_exp     = '0;
        Rst_n        = 1'b0;
        Stall        = 1'b0;
        FlushIF      = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = 32'h0;
        IMemReady    = 1'b0;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_req", {63'd0, IMemReq}, 64'd0);
        chk("rst_addr", {32'd0, IMemAddr}, 64'd0);
        chk("rst_instr", {32'd0, Instruction_ID}, 64'd0);
        chk("rst_pc4", {32'd0, PCPlus4_ID}, 64'd0);
        chk("rst_valid", {63'd0, Valid_ID}, 64'd0);

        // Streaming fetch with zero-wait memory
        Rst_n     = 1'b1;
        IMemReady = 1'b1;
        #1;
        chk("t1_req", {63'd0, IMemReq}, 64'd1);
        chk("t1_addr0", {32'd0, IMemAddr}, 64'h0);
        push(32'h0);
        tick();
        chk("t1_addr4", {32'd0, IMemAddr}, 64'h4);
        push(32'h4);
        tick();
        chk("t1_addr8", {32'd0, IMemAddr}, 64'h8);

        // Stall while word@8 returns: parked in skid, IF/ID frozen
        Stall = 1'b1;
        push(32'h8);
        tick();
        chk("t2_req_held", {63'd0, IMemReq}, 64'd0);
        chk("t2_pc12", {32'd0, IMemAddr}, 64'hC);
        tick();
        chk("t2_req_held2", {63'd0, IMemReq}, 64'd0);
        tick();
        chk("t2_req_held3", {63'd0, IMemReq}, 64'd0);
        Stall = 1'b0;
        tick();
        chk("t2_req_rel", {63'd0, IMemReq}, 64'd1);
        chk("t2_addr12", {32'd0, IMemAddr}, 64'hC);

        // Fill skid with word@12 under stall, then branch discards it
        Stall = 1'b1;
        tick();
        chk("t3_held", {63'd0, IMemReq}, 64'd0);
        BranchTaken  = 1'b1;
        BranchTarget = 32'h40;
        tick();
        BranchTaken = 1'b0;
        chk("t3_valid", {63'd0, Valid_ID}, 64'd0);
        chk("t3_addr", {32'd0, IMemAddr}, 64'h40);
        chk("t3_req", {63'd0, IMemReq}, 64'd1);
        Stall = 1'b0;
        push(32'h40);
        tick();

        // Flush with a return at PC=0x10: word dropped, PC still advances
        BranchTaken  = 1'b1;
        BranchTarget = 32'h10;
        tick();
        BranchTaken = 1'b0;
        chk("t4_addr10", {32'd0, IMemAddr}, 64'h10);
        FlushIF = 1'b1;
        tick();
        FlushIF = 1'b0;
        chk("t4_valid", {63'd0, Valid_ID}, 64'd0);
        chk("t4_addr14", {32'd0, IMemAddr}, 64'h14);
        push(32'h14);
        tick();

        // Memory wait: bubbles, stable address, async reset mid-wait
        IMemReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t5_addr_stable", {32'd0, IMemAddr}, 64'h18);
            chk("t5_req", {63'd0, IMemReq}, 64'd1);
        end
        Rst_n = 1'b0;
        #2;
        chk("t5_rst_req", {63'd0, IMemReq}, 64'd0);
        chk("t5_rst_addr", {32'd0, IMemAddr}, 64'h0);
        chk("t5_rst_valid", {63'd0, Valid_ID}, 64'd0);
        chk("t5_rst_pc4", {32'd0, PCPlus4_ID}, 64'd0);
        Rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t5_addr_post", {32'd0, IMemAddr}, 64'h0);
        end
        IMemReady = 1'b1;
        push(32'h0);
        tick();
        chk("t5_refetch", {32'd0, IMemAddr}, 64'h4);

        // PC wrap at the top of the address space
        BranchTaken  = 1'b1;
        BranchTarget = 32'hFFFF_FFFC;
        tick();
        BranchTaken = 1'b0;
        chk("t6_addr_top", {32'd0, IMemAddr}, 64'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        tick();
        chk("t6_pc4_wrap", {32'd0, PCPlus4_ID}, 64'h0);
        chk("t6_addr_wrap", {32'd0, IMemAddr}, 64'h0);
        push(32'h0);
        tick();

        IMemReady = 1'b0;
        tick();
        chk("sb_drained", {32'd0, sb.size()}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
